// File: rtl/vera_pkg.sv
// Shared types and default widths for the VRAM arbiter slice.
// Owner codes tag which port the memory read data returning next cycle belongs to.
package vera_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnP0   = 2'd1,
        OwnP1   = 2'd2,
        OwnP2   = 2'd3
    } owner_e;

    typedef enum logic {
        LastP1 = 1'b0,
        LastP2 = 1'b1
    } last_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the CPU port, two fetch ports, the memory port and the arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = vera_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = vera_pkg::DEF_DATA_W
);

    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wrdata;
    logic              p0_strobe;
    logic              p0_write;
    logic [DATA_W-1:0] p0_rddata;

    logic              p1_req;
    logic              p2_req;
    logic [ADDR_W-1:0] p1_addr;
    logic [ADDR_W-1:0] p2_addr;
    logic              p1_ack;
    logic              p2_ack;
    logic [DATA_W-1:0] p1_rddata;
    logic [DATA_W-1:0] p2_rddata;
    logic              p1_rdvalid;
    logic              p2_rdvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wrdata;
    logic              mem_strobe;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rddata;

    modport slave (
        input  p0_addr, p0_wrdata, p0_strobe, p0_write,
        input  p1_req, p2_req, p1_addr, p2_addr,
        input  mem_rddata,
        output p0_rddata, p1_ack, p2_ack, p1_rddata, p2_rddata, p1_rdvalid, p2_rdvalid,
        output mem_addr, mem_wrdata, mem_strobe, mem_write
    );

    modport master (
        output p0_addr, p0_wrdata, p0_strobe, p0_write,
        output p1_req, p2_req, p1_addr, p2_addr,
        output mem_rddata,
        input  p0_rddata, p1_ack, p2_ack, p1_rddata, p2_rddata, p1_rdvalid, p2_rdvalid,
        input  mem_addr, mem_wrdata, mem_strobe, mem_write
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin selector; the grant is combinational and the
// last-granted side only moves when a grant is actually issued.
module arb_rr2
    import vera_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    last_e last_d, last_q;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (advance) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_q == LastP2) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        if (grant[0]) begin
            last_d = LastP1;
        end else if (grant[1]) begin
            last_d = LastP2;
        end
    end

    // Reset to P2 so that P1 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LastP2;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: CPU port p0 has absolute priority and is never stalled; fetch ports
// p1/p2 share the remaining cycles round-robin. All reads return one cycle later.
module vram_arbiter
    import vera_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    vram_arbiter_if.slave bus
);

    logic              p0_go;
    logic [1:0]        fetch_req;
    logic [1:0]        grant;
    owner_e            owner_d, owner_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0] mem_wrdata_d, mem_wrdata_q;
    logic              mem_strobe, mem_write;
    logic [DATA_W-1:0] p0_rddata_q, p1_rddata_q, p2_rddata_q;

    // Requests are masked during reset so the memory port stays idle.
    assign p0_go     = bus.p0_strobe & rst_n;
    assign fetch_req = {bus.p2_req, bus.p1_req} & {2{rst_n}};

    arb_rr2 u_arb_rr2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (fetch_req),
        .advance(~p0_go),
        .grant  (grant)
    );

    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wrdata_d = mem_wrdata_q;
        mem_strobe   = 1'b0;
        mem_write    = 1'b0;
        owner_d      = OwnNone;
        if (p0_go) begin
            mem_addr_d   = bus.p0_addr;
            mem_wrdata_d = bus.p0_wrdata;
            mem_strobe   = 1'b1;
            mem_write    = bus.p0_write;
            owner_d      = bus.p0_write ? OwnNone : OwnP0;
        end else if (grant[0]) begin
            mem_addr_d = bus.p1_addr;
            mem_strobe = 1'b1;
            owner_d    = OwnP1;
        end else if (grant[1]) begin
            mem_addr_d = bus.p2_addr;
            mem_strobe = 1'b1;
            owner_d    = OwnP2;
        end
    end

    assign bus.p1_ack     = grant[0];
    assign bus.p2_ack     = grant[1];
    assign bus.mem_addr   = mem_addr_d;
    assign bus.mem_wrdata = mem_wrdata_d;
    assign bus.mem_strobe = mem_strobe;
    assign bus.mem_write  = mem_write;

    // Returning data passes straight through in its cycle, then the register holds it.
    assign bus.p0_rddata  = (owner_q == OwnP0) ? bus.mem_rddata : p0_rddata_q;
    assign bus.p1_rddata  = (owner_q == OwnP1) ? bus.mem_rddata : p1_rddata_q;
    assign bus.p2_rddata  = (owner_q == OwnP2) ? bus.mem_rddata : p2_rddata_q;
    assign bus.p1_rdvalid = (owner_q == OwnP1);
    assign bus.p2_rdvalid = (owner_q == OwnP2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OwnNone;
            mem_addr_q   <= '0;
            mem_wrdata_q <= '0;
            p0_rddata_q  <= '0;
            p1_rddata_q  <= '0;
            p2_rddata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrdata_q <= mem_wrdata_d;
            if (owner_q == OwnP0) p0_rddata_q <= bus.mem_rddata;
            if (owner_q == OwnP1) p1_rddata_q <= bus.mem_rddata;
            if (owner_q == OwnP2) p2_rddata_q <= bus.mem_rddata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, reset corner case,
// and randomized traffic checked against a cycle-level reference model.
module tb_vram_arbiter;
    import vera_pkg::*;

    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned DW = DEF_DATA_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] seed_byte(input logic [19:0] a);
        return (a == 20'h1F9C0) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    // Memory: data valid the cycle after a read strobe, garbage otherwise.
    logic [7:0] mem_arr [0:(1<<20)-1];
    bit         mem_vld [0:(1<<20)-1];
    always @(posedge clk) begin
        if (bus.mem_strobe && bus.mem_write) begin
            mem_arr[bus.mem_addr] <= bus.mem_wrdata;
            mem_vld[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_strobe && !bus.mem_write)
            bus.mem_rddata <= mem_vld[bus.mem_addr] ? mem_arr[bus.mem_addr]
                                                    : seed_byte(bus.mem_addr);
        else
            bus.mem_rddata <= 8'($urandom);
    end

    // Reference model state
    logic [7:0]  gold [int];
    int          m_last;
    owner_e      m_prev;
    logic [19:0] m_prev_addr, m_held_addr;
    logic [7:0]  m_hold0, m_hold1, m_hold2;
    logic        m_ack1, m_ack2;
    int          m_w1, m_w2;
    bit          m_wait_chk;

    function automatic logic [7:0] gold_rd(input logic [19:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : seed_byte(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wait(input string name, input int w);
        n_tests++;
        if (w > 3) begin
            n_fail++;
            $display("FAIL %s: waited %0d cycles, limit 3", name, w);
        end
    endtask

    task automatic model_reset();
        m_last = 2;
        m_prev = OwnNone;
        m_prev_addr = '0;
        m_held_addr = '0;
        m_hold0 = '0;
        m_hold1 = '0;
        m_hold2 = '0;
        m_ack1 = 1'b0;
        m_ack2 = 1'b0;
        m_w1 = 0;
        m_w2 = 0;
    endtask

    // Evaluate one cycle at the negedge: predict, compare, then commit.
    task automatic model_cycle();
        int          g;
        logic        st, wr;
        logic [19:0] ea;
        owner_e      now;
        g = 0; st = 1'b0; wr = 1'b0; ea = m_held_addr; now = OwnNone;
        if (bus.p0_strobe) begin
            st = 1'b1; wr = bus.p0_write; ea = bus.p0_addr;
            now = bus.p0_write ? OwnNone : OwnP0;
        end else begin
            if (bus.p1_req && bus.p2_req) g = (m_last == 1) ? 2 : 1;
            else if (bus.p1_req)          g = 1;
            else if (bus.p2_req)          g = 2;
            if (g != 0) begin
                st = 1'b1;
                ea = (g == 1) ? bus.p1_addr : bus.p2_addr;
                now = (g == 1) ? OwnP1 : OwnP2;
                m_last = g;
            end
        end
        m_ack1 = (g == 1);
        m_ack2 = (g == 2);
        check("p1_ack", bus.p1_ack, m_ack1);
        check("p2_ack", bus.p2_ack, m_ack2);
        check("mem_strobe", bus.mem_strobe, st);
        check("mem_write", bus.mem_write, wr);
        check("mem_addr", bus.mem_addr, ea);
        if (bus.p0_strobe && bus.p0_write) check("mem_wrdata", bus.mem_wrdata, bus.p0_wrdata);

        if (m_prev == OwnP0) m_hold0 = gold_rd(m_prev_addr);
        if (m_prev == OwnP1) m_hold1 = gold_rd(m_prev_addr);
        if (m_prev == OwnP2) m_hold2 = gold_rd(m_prev_addr);
        check("p1_rdvalid", bus.p1_rdvalid, m_prev == OwnP1);
        check("p2_rdvalid", bus.p2_rdvalid, m_prev == OwnP2);
        check("p0_rddata", bus.p0_rddata, m_hold0);
        check("p1_rddata", bus.p1_rddata, m_hold1);
        check("p2_rddata", bus.p2_rddata, m_hold2);

        if (m_wait_chk) begin
            if (bus.p1_req) m_w1++;
            if (bus.p2_req) m_w2++;
            if (bus.p1_ack) begin check_wait("p1_wait", m_w1); m_w1 = 0; end
            if (bus.p2_ack) begin check_wait("p2_wait", m_w2); m_w2 = 0; end
        end

        if (bus.p0_strobe && bus.p0_write) gold[int'(bus.p0_addr)] = bus.p0_wrdata;
        m_prev = now;
        m_prev_addr = ea;
        m_held_addr = ea;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.p0_strobe = 1'b0; bus.p0_write = 1'b0; bus.p0_addr = '0; bus.p0_wrdata = '0;
        bus.p1_req = 1'b0; bus.p2_req = 1'b0; bus.p1_addr = '0; bus.p2_addr = '0;
    endtask

    typedef struct {
        logic p0s; logic p0w; logic [19:0] a0; logic [7:0] d0;
        logic r1; logic r2; logic [19:0] a1; logic [19:0] a2;
        logic e1; logic e2; logic est; logic ewr; logic [19:0] eaddr;
        logic crd; logic [7:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic p0s, input logic p0w, input logic [19:0] a0,
                                input logic [7:0] d0, input logic r1, input logic r2,
                                input logic [19:0] a1, input logic [19:0] a2, input logic e1,
                                input logic e2, input logic est, input logic ewr,
                                input logic [19:0] eaddr, input logic crd,
                                input logic [7:0] erd);
        vec_t v;
        v.p0s = p0s; v.p0w = p0w; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.r2 = r2;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.est = est; v.ewr = ewr;
        v.eaddr = eaddr; v.crd = crd; v.erd = erd;
        return v;
    endfunction

    task automatic rnd_phase(input int ncyc, input bit every3);
        m_wait_chk = every3;
        m_w1 = 0;
        m_w2 = 0;
        set_idle();
        for (int c = 0; c < ncyc; c++) begin
            if (!bus.p1_req || m_ack1) begin
                bus.p1_req  = every3 ? 1'b1 : 1'($urandom_range(0, 1));
                bus.p1_addr = 20'($urandom_range(0, 15));
            end
            if (!bus.p2_req || m_ack2) begin
                bus.p2_req  = every3 ? 1'b1 : 1'($urandom_range(0, 1));
                bus.p2_addr = 20'($urandom_range(0, 15));
            end
            bus.p0_strobe = every3 ? (c % 3 == 0) : ($urandom_range(0, 2) == 0);
            bus.p0_write  = 1'($urandom_range(0, 1));
            bus.p0_addr   = 20'($urandom_range(0, 15));
            bus.p0_wrdata = 8'($urandom);
            @(negedge clk);
            model_cycle();
            tick();
        end
        set_idle();
        @(negedge clk);
        model_cycle();
        tick();
        m_wait_chk = 1'b0;
    endtask

    vec_t vecs [15];

    initial begin
        vecs[0]  = mk(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 20'h0, 20'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 8'h0);
        vecs[1]  = mk(1'b1, 1'b0, 20'h1F9C0, 8'h0, 1'b0, 1'b0, 20'h0, 20'h0,
                      1'b0, 1'b0, 1'b1, 1'b0, 20'h1F9C0, 1'b0, 8'h0);
        vecs[2]  = mk(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 20'h0, 20'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 20'h1F9C0, 1'b1, 8'hA5);
        vecs[3]  = mk(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 20'h0, 20'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 20'h1F9C0, 1'b1, 8'hA5);
        for (int i = 4; i < 10; i++)
            vecs[i] = mk(1'b0, 1'b0, 20'h0, 8'h0, 1'b1, 1'b1, 20'h00100, 20'h00200,
                         (i % 2 == 0), (i % 2 == 1), 1'b1, 1'b0,
                         (i % 2 == 0) ? 20'h00100 : 20'h00200, 1'b0, 8'h0);
        vecs[10] = mk(1'b1, 1'b1, 20'h00010, 8'h3C, 1'b1, 1'b0, 20'h00100, 20'h0,
                      1'b0, 1'b0, 1'b1, 1'b1, 20'h00010, 1'b0, 8'h0);
        vecs[11] = mk(1'b0, 1'b0, 20'h0, 8'h0, 1'b1, 1'b0, 20'h00100, 20'h0,
                      1'b1, 1'b0, 1'b1, 1'b0, 20'h00100, 1'b0, 8'h0);
        vecs[12] = mk(1'b1, 1'b0, 20'h00010, 8'h0, 1'b0, 1'b0, 20'h0, 20'h0,
                      1'b0, 1'b0, 1'b1, 1'b0, 20'h00010, 1'b0, 8'h0);
        vecs[13] = mk(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 20'h0, 20'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 1'b1, 8'h3C);
        vecs[14] = mk(1'b0, 1'b0, 20'h0, 8'h0, 1'b0, 1'b0, 20'h0, 20'h0,
                      1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 1'b1, 8'h3C);

        // Reset with every request active: outputs must stay quiet.
        m_wait_chk = 1'b0;
        model_reset();
        rst_n = 1'b0;
        set_idle();
        bus.p0_strobe = 1'b1; bus.p0_write = 1'b1; bus.p0_addr = 20'h12345;
        bus.p0_wrdata = 8'h77; bus.p1_req = 1'b1; bus.p2_req = 1'b1;
        bus.p1_addr = 20'h00111; bus.p2_addr = 20'h00222;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_p1_ack", bus.p1_ack, 0);
        check("rst_p2_ack", bus.p2_ack, 0);
        check("rst_mem_strobe", bus.mem_strobe, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wrdata", bus.mem_wrdata, 0);
        check("rst_p1_rdvalid", bus.p1_rdvalid, 0);
        check("rst_p2_rdvalid", bus.p2_rdvalid, 0);
        check("rst_p0_rddata", bus.p0_rddata, 0);
        check("rst_p1_rddata", bus.p1_rddata, 0);
        check("rst_p2_rddata", bus.p2_rddata, 0);
        tick();
        set_idle();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus.p0_strobe = vecs[i].p0s; bus.p0_write = vecs[i].p0w;
            bus.p0_addr = vecs[i].a0; bus.p0_wrdata = vecs[i].d0;
            bus.p1_req = vecs[i].r1; bus.p2_req = vecs[i].r2;
            bus.p1_addr = vecs[i].a1; bus.p2_addr = vecs[i].a2;
            @(negedge clk);
            model_cycle();
            check($sformatf("v%0d_p1_ack", i), bus.p1_ack, vecs[i].e1);
            check($sformatf("v%0d_p2_ack", i), bus.p2_ack, vecs[i].e2);
            check($sformatf("v%0d_mem_strobe", i), bus.mem_strobe, vecs[i].est);
            check($sformatf("v%0d_mem_write", i), bus.mem_write, vecs[i].ewr);
            check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].eaddr);
            if (vecs[i].crd) check($sformatf("v%0d_p0_rddata", i), bus.p0_rddata, vecs[i].erd);
            tick();
        end

        // Reset right after a p2 grant: the in-flight read must vanish.
        set_idle();
        bus.p1_req = 1'b1; bus.p2_req = 1'b1;
        bus.p1_addr = 20'h00300; bus.p2_addr = 20'h00400;
        @(negedge clk);
        model_cycle();
        check("r39_p2_ack", bus.p2_ack, 1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("r39_p2_rdvalid", bus.p2_rdvalid, 0);
        check("r39_p1_ack", bus.p1_ack, 0);
        check("r39_p2_ack_rst", bus.p2_ack, 0);
        check("r39_mem_strobe", bus.mem_strobe, 0);
        check("r39_mem_addr", bus.mem_addr, 0);
        check("r39_p0_rddata", bus.p0_rddata, 0);
        check("r39_p2_rddata", bus.p2_rddata, 0);
        tick();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        model_cycle();
        check("r39_first_tie_p1", bus.p1_ack, 1);
        check("r39_no_late_p2_rdvalid", bus.p2_rdvalid, 0);
        tick();
        set_idle();
        @(negedge clk);
        model_cycle();
        tick();

        rnd_phase(600, 1'b1);
        rnd_phase(600, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
